fifo_rtl_2: RTL and testbench
=============================

Name: fifo_rtl_2

Overview:
Parametrised second-generation synchronous FIFO; successor to fifo_rtl_1 with the same core handshake (wt_en/rd_en, full/empty, overflow/underflow).
Adds programmable almost-full/almost-empty thresholds, an exposed fill level, a read-data-valid strobe and defined simultaneous read/write behaviour at full.
Sits between a producer and a consumer in one clock domain.

Parameters:
WIDTH, 8, data width in bits (>=1)
DEPTH, 16, entries; power of two, >=2; AW = $clog2(DEPTH)
AF_TH, DEPTH-2, almost_full asserted when ct >= AF_TH (1..DEPTH)
AE_TH, 2, almost_empty asserted when ct <= AE_TH (0..DEPTH-1)
CNT_W, 16, width of error counters (optional feature)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
wt_en  in  1  write request
din  in  WIDTH  write data
rd_en  in  1  read request
dout  out  WIDTH  registered read data
dout_vld  out  1  dout updated this cycle (one-cycle pulse)
full  out  1  ct == DEPTH
empty  out  1  ct == 0
almost_full  out  1  ct >= AF_TH
almost_empty  out  1  ct <= AE_TH
ct  out  AW+1  current fill level, 0..DEPTH
overflow  out  1  registered: previous cycle's write was rejected
underflow  out  1  registered: previous cycle's read was rejected
ovf_cnt  out  CNT_W  saturating rejected-write count (optional feature)
udf_cnt  out  CNT_W  saturating rejected-read count (optional feature)
cnt_clr  in  1  synchronous clear of both counters (optional feature)

Behaviour:
- Single clock clk; reset is synchronous and active-high on rst. rst dominates all other inputs in the same cycle.
- Reset values: wt_p=0, rd_p=0, ct=0, dout=0, dout_vld=0, overflow=0, underflow=0, empty=1, full=0, almost_empty=1, almost_full=(AF_TH==0). Memory is not cleared.
- Read accept: rd_acc = rd_en && !empty.
- Write accept: wt_acc = wt_en && (!full || rd_acc). A write at full is accepted when a read is accepted in the same cycle.
- Accepted write: mem[wt_p] <= din; wt_p <= wt_p+1, wrapping modulo DEPTH.
- Accepted read: dout <= mem[rd_p]; rd_p increments with wrap; dout_vld=1 the next cycle. Read latency is 1 cycle.
- dout holds its value when no read is accepted.
- Level: ct <= ct + wt_acc - rd_acc. Simultaneous accepted read and write leaves ct unchanged.
- Flags are combinational from the ct register only, so they reflect the state after the last edge.
- Empty + rd_en + wt_en: the read is rejected (underflow=1 next cycle), the write is accepted, ct becomes 1. No write-through bypass.
- Full + wt_en without rd_en: the write is rejected, overflow=1 next cycle, memory and pointers are unchanged.
- overflow/underflow stay high for every consecutive rejected cycle; they are not sticky.
- Reset mid-operation: any same-cycle write or read is discarded; the next cycle shows the reset state.

Optional Feature:
- Macro: FIFO_ERR_CNT_EN.
- Defined:
  - ovf_cnt increments on each cycle with a rejected write; udf_cnt increments on each cycle with a rejected read.
  - Both saturate at 2^CNT_W-1.
  - Both clear on rst or cnt_clr. cnt_clr takes priority over an increment in the same cycle.
- Undefined: ovf_cnt and udf_cnt are driven constant 0, cnt_clr is ignored, no counter flops are synthesised. The port list is identical in both builds.

Decomposition:
- Package fifo_pkg: function to compute AW from DEPTH; localparam CNT_W_DEF=16; an elaboration-time check function for DEPTH power of two and for AF_TH/AE_TH ranges.
- Sub-module fifo_mem_2: simple dual-port register array with WIDTH and DEPTH parameters, one write port and one registered read port. fifo_rtl_2 owns pointers, level, flags and counters.

Test Plan:
1. Reset, then write 0x01..0x03 on 3 consecutive cycles -> ct=3, empty=0, almost_empty=0 (AE_TH=2 once ct reaches 3); read 3 cycles -> dout 0x01,0x02,0x03 each one cycle after rd_en, with dout_vld pulses.
2. Read 6 cycles when empty -> underflow high 6 cycles, ct stays 0, dout unchanged; with FIFO_ERR_CNT_EN, udf_cnt=6.
3. Write 16 words -> almost_full at ct=14, full at ct=16; 17th write without read -> overflow=1 one cycle, ct=16; drain -> data in order, no loss or duplication.
4. At full, wt_en and rd_en together for 10 cycles -> ct stays 16, no overflow, data read matches FIFO order, pointers wrap past 15.
5. At ct=5, assert rst with wt_en=rd_en=1 -> next cycle ct=0, empty=1, dout=0, overflow=0, underflow=0; the write that cycle is not stored.
6. With FIFO_ERR_CNT_EN and CNT_W=4: hold wt_en at full for 20 cycles -> ovf_cnt saturates at 15; pulse cnt_clr -> 0. Without the macro -> ovf_cnt=0 throughout.

Source files
------------

// File: rtl/fifo_rtl_2_pkg.sv
// Shared definitions for the fifo_rtl_2 slice: address-width helper, default
// error-counter width and an elaboration-time parameter legality check.
// Optional feature macro used by this slice: FIFO_ERR_CNT_EN.
package fifo_pkg;

  localparam int CNT_W_DEF = 16;

  // Address width needed to index DEPTH entries.
  function automatic int calc_aw(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  // True when the FIFO parameters describe a legal configuration.
  function automatic bit params_ok(input int width, input int depth,
                                   input int af_th, input int ae_th,
                                   input int cnt_w);
    bit ok;
    ok = 1'b1;
    if (width < 1)                          ok = 1'b0;
    if (depth < 2)                          ok = 1'b0;
    if ((depth & (depth - 1)) != 0)         ok = 1'b0;
    if (af_th < 1 || af_th > depth)         ok = 1'b0;
    if (ae_th < 0 || ae_th > depth - 1)     ok = 1'b0;
    if (cnt_w < 1)                          ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/fifo_rtl_2_if.sv
// Producer/consumer-facing bundle of the fifo_rtl_2 block. The master modport
// is the user side (producer + consumer), the slave modport is the FIFO.
// Error-counter signals exist in every build; FIFO_ERR_CNT_EN only changes
// whether the FIFO drives them with live values.
interface fifo_rtl_2_if
  import fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int CNT_W = CNT_W_DEF
);
  localparam int AW = calc_aw(DEPTH);

  logic             wt_en;
  logic [WIDTH-1:0] din;
  logic             rd_en;
  logic             cnt_clr;
  logic [WIDTH-1:0] dout;
  logic             dout_vld;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [AW:0]      ct;
  logic             overflow;
  logic             underflow;
  logic [CNT_W-1:0] ovf_cnt;
  logic [CNT_W-1:0] udf_cnt;

  modport master (
    output wt_en, din, rd_en, cnt_clr,
    input  dout, dout_vld, full, empty, almost_full, almost_empty, ct,
           overflow, underflow, ovf_cnt, udf_cnt
  );

  modport slave (
    input  wt_en, din, rd_en, cnt_clr,
    output dout, dout_vld, full, empty, almost_full, almost_empty, ct,
           overflow, underflow, ovf_cnt, udf_cnt
  );
endinterface

// File: rtl/fifo_rtl_2_mem.sv
// fifo_mem_2: simple dual-port register array, one write port and one
// registered read port. Only the read register is reset.
module fifo_mem_2 #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];

  // Write port.
  // NOTE: the storage array has no reset; occupancy is tracked by the
  // pointers, so clearing it would only cost a reset net on every bit.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read port; holds its value when no read is issued.
  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/fifo_rtl_2.sv
// fifo_rtl_2: synchronous FIFO with fill level, programmable almost flags,
// read-valid strobe, registered overflow/underflow and, when FIFO_ERR_CNT_EN
// is defined, saturating rejected-write/read counters.
module fifo_rtl_2
  import fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AF_TH = DEPTH - 2,
  parameter int AE_TH = 2,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  fifo_rtl_2_if.slave  bus
);
  localparam int AW = calc_aw(DEPTH);
  localparam logic [AW:0] DEPTH_LVL = (AW + 1)'(DEPTH);
  localparam logic [AW:0] AF_LVL    = (AW + 1)'(AF_TH);
  localparam logic [AW:0] AE_LVL    = (AW + 1)'(AE_TH);

  if (!params_ok(WIDTH, DEPTH, AF_TH, AE_TH, CNT_W)) begin : g_bad_params
    $fatal(1, "fifo_rtl_2: illegal WIDTH/DEPTH/AF_TH/AE_TH/CNT_W");
  end

  logic [AW-1:0] wt_p, rd_p;
  logic [AW:0]   ct_q;
  logic          rd_acc, wt_acc, wt_rej, rd_rej;

  // Accept logic; reset discards any request in the same cycle.
  always_comb begin
    rd_acc = !rst && bus.rd_en && (ct_q != '0);
    wt_acc = !rst && bus.wt_en && ((ct_q != DEPTH_LVL) || rd_acc);
    wt_rej = !rst && bus.wt_en && !wt_acc;
    rd_rej = !rst && bus.rd_en && !rd_acc;
  end

  // Pointers, fill level, read strobe and error flags.
  // NOTE: every register here uses non-blocking assignment so all of them
  // update from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wt_p          <= '0;
      rd_p          <= '0;
      ct_q          <= '0;
      bus.dout_vld  <= 1'b0;
      bus.overflow  <= 1'b0;
      bus.underflow <= 1'b0;
    end else begin
      if (wt_acc) wt_p <= wt_p + 1'b1;
      if (rd_acc) rd_p <= rd_p + 1'b1;
      unique case ({wt_acc, rd_acc})
        2'b10:   ct_q <= ct_q + 1'b1;
        2'b01:   ct_q <= ct_q - 1'b1;
        default: ct_q <= ct_q;
      endcase
      bus.dout_vld  <= rd_acc;
      bus.overflow  <= wt_rej;
      bus.underflow <= rd_rej;
    end
  end

  // Status flags decode the level register only.
  always_comb begin
    bus.ct           = ct_q;
    bus.empty        = (ct_q == '0);
    bus.full         = (ct_q == DEPTH_LVL);
    bus.almost_full  = (ct_q >= AF_LVL);
    bus.almost_empty = (ct_q <= AE_LVL);
  end

  fifo_mem_2 #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (wt_acc),
    .waddr (wt_p),
    .wdata (bus.din),
    .re    (rd_acc),
    .raddr (rd_p),
    .rdata (bus.dout)
  );

`ifdef FIFO_ERR_CNT_EN
  logic [CNT_W-1:0] ovf_cnt_q, udf_cnt_q;

  // Saturating error counters; clear wins over increment.
  always_ff @(posedge clk) begin
    if (rst || bus.cnt_clr) begin
      ovf_cnt_q <= '0;
      udf_cnt_q <= '0;
    end else begin
      if (wt_rej && !(&ovf_cnt_q)) ovf_cnt_q <= ovf_cnt_q + 1'b1;
      if (rd_rej && !(&udf_cnt_q)) udf_cnt_q <= udf_cnt_q + 1'b1;
    end
  end

  assign bus.ovf_cnt = ovf_cnt_q;
  assign bus.udf_cnt = udf_cnt_q;
`else
  // Counters compiled out: outputs tied low, clear input ignored.
  assign bus.ovf_cnt = '0;
  assign bus.udf_cnt = '0;
  logic unused_cnt_clr;
  assign unused_cnt_clr = bus.cnt_clr;
`endif

endmodule

// File: tb/tb_fifo_rtl_2.sv
// Testbench for fifo_rtl_2: directed scenarios followed by random traffic,
// every cycle compared against a queue-based reference model.
module tb_fifo_rtl_2;
  import fifo_pkg::*;

  localparam int WIDTH   = 8;
  localparam int DEPTH   = 16;
  localparam int AF_TH   = DEPTH - 2;
  localparam int AE_TH   = 2;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifo_rtl_2_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

  fifo_rtl_2 #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .AF_TH(AF_TH), .AE_TH(AE_TH), .CNT_W(CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference model state.
  logic [WIDTH-1:0] q[$];
  logic [WIDTH-1:0] m_dout;
  bit               m_vld, m_ovf, m_udf;
  int               m_ovf_cnt, m_udf_cnt;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    check("ct",           32'(bus.ct), q.size());
    check("empty",        32'(bus.empty), 32'(q.size() == 0));
    check("full",         32'(bus.full), 32'(q.size() == DEPTH));
    check("almost_full",  32'(bus.almost_full), 32'(q.size() >= AF_TH));
    check("almost_empty", 32'(bus.almost_empty), 32'(q.size() <= AE_TH));
    check("dout",         32'(bus.dout), 32'(m_dout));
    check("dout_vld",     32'(bus.dout_vld), 32'(m_vld));
    check("overflow",     32'(bus.overflow), 32'(m_ovf));
    check("underflow",    32'(bus.underflow), 32'(m_udf));
    check("ovf_cnt",      32'(bus.ovf_cnt), m_ovf_cnt);
    check("udf_cnt",      32'(bus.udf_cnt), m_udf_cnt);
  endtask

  // Apply one cycle of stimulus, advance the model, then compare.
  task automatic step(input bit wt, input logic [WIDTH-1:0] d, input bit rd,
                      input bit r, input bit clr);
    bit rd_ok, wt_ok;
    bus.wt_en   = wt;
    bus.din     = d;
    bus.rd_en   = rd;
    bus.cnt_clr = clr;
    rst         = r;
    if (r) begin
      q.delete();
      m_dout = '0; m_vld = 0; m_ovf = 0; m_udf = 0;
      m_ovf_cnt = 0; m_udf_cnt = 0;
    end else begin
      rd_ok = rd && (q.size() != 0);
      wt_ok = wt && ((q.size() < DEPTH) || rd_ok);
      m_vld = rd_ok;
      if (rd_ok) m_dout = q.pop_front();
      if (wt_ok) q.push_back(d);
      m_ovf = wt && !wt_ok;
      m_udf = rd && !rd_ok;
`ifdef FIFO_ERR_CNT_EN
      if (clr) begin
        m_ovf_cnt = 0;
        m_udf_cnt = 0;
      end else begin
        if (m_ovf && m_ovf_cnt < CNT_MAX) m_ovf_cnt++;
        if (m_udf && m_udf_cnt < CNT_MAX) m_udf_cnt++;
      end
`endif
    end
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic idle();
    step(0, '0, 0, 0, 0);
  endtask

  task automatic wr(input logic [WIDTH-1:0] d);
    step(1, d, 0, 0, 0);
  endtask

  task automatic rd1();
    step(0, '0, 1, 0, 0);
  endtask

  initial begin
    bus.wt_en = 0; bus.rd_en = 0; bus.din = '0; bus.cnt_clr = 0; rst = 1;

    // Reset state.
    step(0, '0, 0, 1, 0);
    step(1, 8'hAA, 1, 1, 0);
    check("rst_ct", 32'(bus.ct), 0);
    check("rst_almost_full", 32'(bus.almost_full), 0);

    // Three writes then three reads with one-cycle latency.
    wr(8'h01); wr(8'h02); wr(8'h03);
    check("tp1_ct3", 32'(bus.ct), 3);
    check("tp1_ae_low", 32'(bus.almost_empty), 0);
    rd1(); check("tp1_d1", 32'(bus.dout), 32'h01);
    rd1(); check("tp1_d2", 32'(bus.dout), 32'h02);
    rd1(); check("tp1_d3", 32'(bus.dout), 32'h03);
    idle(); check("tp1_vld_drop", 32'(bus.dout_vld), 0);

    // Six reads while empty.
    for (int i = 0; i < 6; i++) begin
      rd1();
      check("tp2_udf", 32'(bus.underflow), 1);
    end
`ifdef FIFO_ERR_CNT_EN
    check("tp2_udf_cnt", 32'(bus.udf_cnt), 6);
`else
    check("tp2_udf_cnt", 32'(bus.udf_cnt), 0);
`endif
    idle(); check("tp2_udf_clear", 32'(bus.underflow), 0);

    // Fill to full, one rejected write, drain.
    for (int i = 0; i < DEPTH; i++) wr(WIDTH'($urandom));
    check("tp3_full", 32'(bus.full), 1);
    wr(8'h5A);
    check("tp3_ovf", 32'(bus.overflow), 1);
    check("tp3_ct16", 32'(bus.ct), DEPTH);
    idle(); check("tp3_ovf_pulse", 32'(bus.overflow), 0);

    // Full with simultaneous read and write: level holds, pointers wrap.
    for (int i = 0; i < 10; i++) begin
      step(1, WIDTH'($urandom), 1, 0, 0);
      check("tp4_ct16", 32'(bus.ct), DEPTH);
    end
    for (int i = 0; i < DEPTH; i++) rd1();
    check("tp3_drained", 32'(bus.empty), 1);

    // Empty with read and write together: write accepted, read rejected.
    step(1, 8'h77, 1, 0, 0);
    check("empty_rw_ct", 32'(bus.ct), 1);
    rd1();

    // Reset mid-operation at level 5.
    for (int i = 0; i < 5; i++) wr(WIDTH'($urandom));
    step(1, 8'hEE, 1, 1, 0);
    check("tp5_ct0", 32'(bus.ct), 0);
    check("tp5_dout0", 32'(bus.dout), 0);
    rd1(); check("tp5_not_stored", 32'(bus.underflow), 1);

    // Saturating overflow counter and clear.
    for (int i = 0; i < DEPTH; i++) wr(WIDTH'($urandom));
    for (int i = 0; i < 20; i++) wr(WIDTH'($urandom));
`ifdef FIFO_ERR_CNT_EN
    check("tp6_sat", 32'(bus.ovf_cnt), CNT_MAX);
`else
    check("tp6_sat", 32'(bus.ovf_cnt), 0);
`endif
    step(1, 8'h11, 0, 0, 1);
    check("tp6_clr", 32'(bus.ovf_cnt), 0);
    for (int i = 0; i < DEPTH; i++) rd1();

    // Random traffic: write-biased, then read-biased, then balanced.
    for (int ph = 0; ph < 3; ph++) begin
      for (int i = 0; i < 200; i++) begin
        step(($urandom_range(0, 99) < (ph == 0 ? 70 : ph == 1 ? 30 : 50)),
             WIDTH'($urandom),
             ($urandom_range(0, 99) < (ph == 0 ? 30 : ph == 1 ? 70 : 50)),
             ($urandom_range(0, 149) == 0),
             ($urandom_range(0, 39) == 0));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
